// File: rtl/spi_loopback_multi.sv
// Command-driven SPI loopback behind spi_dev_core's byte interface with replay/invert/status modes.
// Define SPI_LOOPBACK_LFSR_EN to build the LFSR pattern response mode (command 0x02).
module spi_loopback_multi #(
  parameter int unsigned AWIDTH = 9,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      user_out,
  input  logic            user_out_stb,
  output logic [7:0]      user_in,
  input  logic            user_in_ack,
  input  logic            csn_state,
  input  logic            csn_rise,
  input  logic            csn_fall,
  output logic            busy,
  output logic [AWIDTH:0] last_len,
  output logic            overflow,
  output logic [7:0]      xact_cnt
);
  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int unsigned CW    = AWIDTH + 2;
  localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [1:0] {WAIT_CS, IDLE, CMD, DATA} state_t;
  typedef enum logic [2:0] {M_REPLAY, M_INV, M_LFSR, M_STATUS, M_IGNORE} mode_t;

  state_t          state_reg, state_next;
  mode_t           mode_reg, mode_next;
  logic [AWIDTH:0] wr_ptr_reg, wr_ptr_next;
  logic            ovf_reg, ovf_next;
  logic [CW-1:0]   ack_cnt_reg, ack_cnt_next;
  logic [AWIDTH:0] last_len_reg, last_len_next;
  logic            overflow_reg, overflow_next;
  logic [7:0]      xact_cnt_reg, xact_cnt_next;
  logic            ld1_reg, ld2_reg;
  logic [CW-1:0]   sel_reg;
  logic [7:0]      rd_data_reg, user_in_reg, resp;
  logic [CW-1:0]   k;
  logic [15:0]     len16;
  logic            oob, mem_we, in_xact, stores;
  logic [AWIDTH-1:0] rd_addr;
  logic [7:0]      mem [DEPTH];
`ifdef SPI_LOOPBACK_LFSR_EN
  logic [7:0]      lfsr_reg;
`endif

  function automatic mode_t decode(input logic [7:0] cmd);
    case (cmd)
      8'h00:   return M_REPLAY;
      8'h01:   return M_INV;
`ifdef SPI_LOOPBACK_LFSR_EN
      8'h02:   return M_LFSR;
`endif
      8'h03:   return M_STATUS;
      default: return M_IGNORE;
    endcase
  endfunction

  assign in_xact = (state_reg == CMD) || (state_reg == DATA);
  assign stores  = (mode_reg == M_REPLAY) || (mode_reg == M_INV) || (mode_reg == M_LFSR);

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    wr_ptr_next   = wr_ptr_reg;
    ovf_next      = ovf_reg;
    ack_cnt_next  = ack_cnt_reg;
    last_len_next = last_len_reg;
    overflow_next = overflow_reg;
    xact_cnt_next = xact_cnt_reg;
    mem_we        = 1'b0;
    if (in_xact && user_in_ack && ack_cnt_reg != '1)
      ack_cnt_next = ack_cnt_reg + 1'b1;
    case (state_reg)
      WAIT_CS: if (csn_state) state_next = IDLE;
      IDLE: begin
        wr_ptr_next  = '0;
        ovf_next     = 1'b0;
        ack_cnt_next = '0;
        if (csn_fall) state_next = CMD;
      end
      CMD: begin
        if (csn_rise) begin
          state_next = IDLE;
        end else if (user_out_stb) begin
          mode_next  = decode(user_out);
          state_next = DATA;
        end
      end
      DATA: begin
        if (user_out_stb && stores) begin
          if (wr_ptr_reg == FULL) begin
            ovf_next = 1'b1;
          end else begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
        end
        // A byte arriving with csn_rise is already folded into wr_ptr_next/ovf_next.
        if (csn_rise) begin
          state_next = IDLE;
          if (stores) begin
            last_len_next = wr_ptr_next;
            overflow_next = ovf_next;
            xact_cnt_next = xact_cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = WAIT_CS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_CS;
      mode_reg     <= M_REPLAY;
      wr_ptr_reg   <= '0;
      ovf_reg      <= 1'b0;
      ack_cnt_reg  <= '0;
      last_len_reg <= '0;
      overflow_reg <= 1'b0;
      xact_cnt_reg <= '0;
      ld1_reg      <= 1'b0;
      ld2_reg      <= 1'b0;
      sel_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      wr_ptr_reg   <= wr_ptr_next;
      ovf_reg      <= ovf_next;
      ack_cnt_reg  <= ack_cnt_next;
      last_len_reg <= last_len_next;
      overflow_reg <= overflow_next;
      xact_cnt_reg <= xact_cnt_next;
      // Reload the transmit byte once per ack, and once more after the command is decoded.
      ld1_reg      <= in_xact && (user_in_ack || (state_reg == CMD && user_out_stb && !csn_rise));
      ld2_reg      <= ld1_reg && in_xact;
      if (ld1_reg) sel_reg <= ack_cnt_reg;
    end
  end

`ifdef SPI_LOOPBACK_LFSR_EN
  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE)
      lfsr_reg <= 8'h01;
    else if (in_xact && user_in_ack && ack_cnt_reg >= CW'(2))
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end
`endif

  // Read is issued once, right after the ack, so a later write to the same index cannot disturb it.
  assign rd_addr = ack_cnt_reg[AWIDTH-1:0] - AWIDTH'(2);

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_reg[AWIDTH-1:0]] <= user_out;
    if (ld1_reg) rd_data_reg <= mem[rd_addr];
  end

  always_comb begin
    k     = sel_reg - CW'(2);
    oob   = (k >= CW'(DEPTH));
    len16 = 16'(last_len_reg);
    resp  = 8'h00;
    if (sel_reg == '0) begin
      resp = MAGIC;
    end else if (sel_reg == CW'(1)) begin
      resp = ~MAGIC;
    end else begin
      case (mode_reg)
        M_REPLAY: resp = oob ? 8'h00 : rd_data_reg;
        M_INV:    resp = oob ? 8'h00 : ~rd_data_reg;
`ifdef SPI_LOOPBACK_LFSR_EN
        M_LFSR:   resp = lfsr_reg;
`endif
        M_STATUS: begin
          if (k == CW'(0))      resp = len16[7:0];
          else if (k == CW'(1)) resp = len16[15:8];
          else if (k == CW'(2)) resp = {overflow_reg, 7'b0};
          else if (k == CW'(3)) resp = xact_cnt_reg;
          else                  resp = 8'h00;
        end
        default:  resp = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !in_xact) user_in_reg <= MAGIC;
    else if (ld2_reg)    user_in_reg <= resp;
  end

  assign user_in  = user_in_reg;
  assign busy     = in_xact;
  assign last_len = last_len_reg;
  assign overflow = overflow_reg;
  assign xact_cnt = xact_cnt_reg;
endmodule

// File: tb/tb_spi_loopback_multi.sv
// Bench for spi_loopback_multi: emulates spi_dev_core byte handshakes and checks against a payload/status model.
`timescale 1ns/1ps
module tb_spi_loopback_multi;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] user_out;
  logic user_out_stb;
  logic [7:0] user_in;
  logic user_in_ack;
  logic csn_state, csn_rise, csn_fall;
  logic busy;
  logic [AW:0] last_len;
  logic overflow;
  logic [7:0] xact_cnt;

  always #5 clk = ~clk;

  spi_loopback_multi #(.AWIDTH(AW), .MAGIC(MAGIC)) dut (
    .clk(clk), .rst(rst),
    .user_out(user_out), .user_out_stb(user_out_stb),
    .user_in(user_in), .user_in_ack(user_in_ack),
    .csn_state(csn_state), .csn_rise(csn_rise), .csn_fall(csn_fall),
    .busy(busy), .last_len(last_len), .overflow(overflow), .xact_cnt(xact_cnt)
  );

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] m_mem [DEPTH];
  bit         m_valid [DEPTH];
  int         m_last_len;
  bit         m_ovf;
  int         m_xact;
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_k(input int steps);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < steps; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  function automatic bit is_store(input logic [7:0] cmd);
`ifdef SPI_LOOPBACK_LFSR_EN
    return cmd <= 8'h02;
`else
    return cmd <= 8'h01;
`endif
  endfunction

  task automatic invalidate_model();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_last_len = 0;
    m_ovf = 1'b0;
    m_xact = 0;
  endtask

  // One CS-low window: ack byte n (capturing MISO n), then strobe MOSI n.
  task automatic run_xact(input bit rise_with_last);
    miso_q.delete();
    csn_state = 1'b0; csn_fall = 1'b1; tick(1); csn_fall = 1'b0; tick(3);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_xact: got %0b expected 1", busy);
    end
    for (int n = 0; n < mosi_q.size(); n++) begin
      miso_q.push_back(user_in);
      user_in_ack = 1'b1; tick(1); user_in_ack = 1'b0; tick(4);
      user_out = mosi_q[n]; user_out_stb = 1'b1;
      if (rise_with_last && n == mosi_q.size() - 1) begin
        csn_rise = 1'b1; csn_state = 1'b1;
      end
      tick(1); user_out_stb = 1'b0; csn_rise = 1'b0; tick(4);
    end
    if (!(rise_with_last && mosi_q.size() > 0)) begin
      csn_state = 1'b1; csn_rise = 1'b1; tick(1); csn_rise = 1'b0;
    end
    tick(4);
  endtask

  task automatic check_xact(input string name);
    logic [7:0] cmd, exp;
    bit chk;
    int p, k;
    cmd = (mosi_q.size() > 0) ? mosi_q[0] : 8'h00;
    for (int n = 0; n < miso_q.size(); n++) begin
      chk = 1'b1; exp = 8'h00; k = n - 2;
      if (n == 0) exp = MAGIC;
      else if (n == 1) exp = ~MAGIC;
      else if (cmd == 8'h00 || cmd == 8'h01) begin
        if (k >= DEPTH) exp = 8'h00;
        else if (!m_valid[k]) chk = 1'b0;
        else exp = (cmd == 8'h00) ? m_mem[k] : ~m_mem[k];
      end else if (cmd == 8'h02) begin
`ifdef SPI_LOOPBACK_LFSR_EN
        exp = lfsr_k(k);
`else
        exp = 8'hFF;
`endif
      end else if (cmd == 8'h03) begin
        case (k)
          0: exp = m_last_len[7:0];
          1: exp = m_last_len[15:8];
          2: exp = {m_ovf, 7'b0};
          3: exp = m_xact[7:0];
          default: exp = 8'h00;
        endcase
      end else exp = 8'hFF;
      if (chk) begin
        n_tests++;
        if (miso_q[n] !== exp) begin
          n_fail++;
          $display("FAIL %s miso[%0d]: got %02h expected %02h", name, n, miso_q[n], exp);
        end
      end
    end
    if (mosi_q.size() > 0 && is_store(cmd)) begin
      p = mosi_q.size() - 1;
      for (int j = 0; j < p && j < DEPTH; j++) begin
        m_mem[j] = mosi_q[j + 1];
        m_valid[j] = 1'b1;
      end
      m_last_len = (p > DEPTH) ? DEPTH : p;
      m_ovf = (p > DEPTH);
      m_xact = (m_xact + 1) % 256;
    end
    n_tests++;
    if (last_len !== m_last_len[AW:0]) begin
      n_fail++;
      $display("FAIL %s last_len: got %0d expected %0d", name, last_len, m_last_len);
    end
    n_tests++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL %s overflow: got %0b expected %0b", name, overflow, m_ovf);
    end
    n_tests++;
    if (xact_cnt !== m_xact[7:0]) begin
      n_fail++;
      $display("FAIL %s xact_cnt: got %0d expected %0d", name, xact_cnt, m_xact);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after: got %0b expected 0", name, busy);
    end
    $display("[TB] %s cmd=%02h bytes=%0d last_len=%0d xact_cnt=%0d", name, cmd, mosi_q.size(), last_len, xact_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; user_out = 8'h5C; user_out_stb = 1'b0; user_in_ack = 1'b0;
    csn_state = 1'b0; csn_rise = 1'b0; csn_fall = 1'b0;
    invalidate_model();
    tick(3); rst = 1'b0; tick(1);
    n_tests++;
    if (user_in !== MAGIC) begin n_fail++; $display("FAIL reset_user_in: got %02h expected %02h", user_in, MAGIC); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_tests++;
    if (last_len !== '0 || overflow !== 1'b0 || xact_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status: got %0d/%0b/%0d expected 0/0/0", last_len, overflow, xact_cnt);
    end
    csn_fall = 1'b1; tick(1); csn_fall = 1'b0; tick(2);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_cs_fall: got busy %0b expected 0", busy); end
    csn_state = 1'b1; tick(3);
  endtask

  task automatic test_replay_invert();
    mosi_q = '{8'h00, 8'h11, 8'h22, 8'h33}; run_xact(1'b0); check_xact("replay_first");
    mosi_q = '{8'h00, 8'h44, 8'h55, 8'h66}; run_xact(1'b0); check_xact("replay_second");
    n_tests++;
    if (miso_q[2] !== 8'h11 || miso_q[3] !== 8'h22) begin
      n_fail++; $display("FAIL replay_const: got %02h %02h expected 11 22", miso_q[2], miso_q[3]);
    end
    mosi_q = '{8'h01, 8'h00, 8'h00, 8'h00}; run_xact(1'b0); check_xact("invert");
    n_tests++;
    if (miso_q[2] !== 8'hBB || miso_q[3] !== 8'hAA) begin
      n_fail++; $display("FAIL invert_const: got %02h %02h expected BB AA", miso_q[2], miso_q[3]);
    end
  endtask

  task automatic test_overflow_status();
    mosi_q.delete(); mosi_q.push_back(8'h00);
    for (int i = 0; i < 20; i++) mosi_q.push_back(8'($urandom));
    run_xact(1'b0); check_xact("overflow");
    mosi_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_xact(1'b0); check_xact("status");
    n_tests++;
    if (miso_q[2] !== 8'h10 || miso_q[3] !== 8'h00 || miso_q[4] !== 8'h80) begin
      n_fail++; $display("FAIL status_const: got %02h %02h %02h expected 10 00 80", miso_q[2], miso_q[3], miso_q[4]);
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_b2;
`ifdef SPI_LOOPBACK_LFSR_EN
    exp_b2 = 8'h01;
`else
    exp_b2 = 8'hFF;
`endif
    mosi_q = '{8'h02, 8'h9A, 8'h3C, 8'hE1, 8'h07}; run_xact(1'b0); check_xact("lfsr_cmd");
    n_tests++;
    if (miso_q[2] !== exp_b2) begin
      n_fail++; $display("FAIL lfsr_first: got %02h expected %02h", miso_q[2], exp_b2);
    end
  endtask

  task automatic test_empty_cs();
    mosi_q.delete(); run_xact(1'b0); check_xact("empty_cs");
    mosi_q = '{8'h00}; run_xact(1'b0); check_xact("cmd_only");
    mosi_q = '{8'h00, 8'hC3, 8'h5A}; run_xact(1'b1); check_xact("rise_with_stb");
  endtask

  task automatic test_random();
    int r, len;
    logic [7:0] cmd;
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 6);
      if (r <= 3) cmd = 8'(r);
      else if (r == 4) cmd = 8'h00;
      else if (r == 5) cmd = 8'h02;
      else cmd = 8'($urandom_range(4, 255));
      len = $urandom_range(0, 20);
      mosi_q.delete(); mosi_q.push_back(cmd);
      for (int i = 0; i < len; i++) mosi_q.push_back(8'($urandom));
      run_xact(1'($urandom_range(0, 1)));
      check_xact("random");
    end
  endtask

  task automatic test_reset_mid();
    csn_state = 1'b0; csn_fall = 1'b1; tick(1); csn_fall = 1'b0; tick(3);
    user_in_ack = 1'b1; tick(1); user_in_ack = 1'b0; tick(4);
    user_out = 8'h00; user_out_stb = 1'b1; tick(1); user_out_stb = 1'b0; tick(4);
    user_in_ack = 1'b1; tick(1); user_in_ack = 1'b0; tick(4);
    user_out = 8'h77; user_out_stb = 1'b1; tick(1); user_out_stb = 1'b0; tick(4);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    invalidate_model();
    n_tests++;
    if (busy !== 1'b0 || user_in !== MAGIC) begin
      n_fail++; $display("FAIL mid_reset_state: got busy %0b user_in %02h expected 0 A5", busy, user_in);
    end
    for (int i = 0; i < 3; i++) begin
      user_in_ack = 1'b1; csn_fall = (i == 1); tick(1); user_in_ack = 1'b0; csn_fall = 1'b0; tick(4);
      user_out = 8'($urandom); user_out_stb = 1'b1; tick(1); user_out_stb = 1'b0; tick(4);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wait: got busy %0b expected 0", busy); end
    csn_state = 1'b1; csn_rise = 1'b1; tick(1); csn_rise = 1'b0; tick(4);
    n_tests++;
    if (last_len !== '0 || xact_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset_status: got %0d/%0d expected 0/0", last_len, xact_cnt);
    end
    mosi_q = '{8'h00, 8'hD1, 8'hD2, 8'hD3}; run_xact(1'b0); check_xact("post_reset");
    mosi_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04}; run_xact(1'b0); check_xact("post_reset_replay");
  endtask

  initial begin
    test_reset();
    test_replay_invert();
    test_overflow_status();
    test_lfsr();
    test_empty_cs();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
